// File: rtl/sram_ctrl_pkg.sv
// rtl/sram_ctrl_pkg.sv - state encoding and strobe counter sizing for the SRAM bus master
package sram_ctrl_pkg;
   localparam int STATE_W = 3;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_WSTRB  = 3'd2,
      S_WHOLD  = 3'd3,
      S_RSTRB  = 3'd4,
      S_TURN   = 3'd5,
      S_VSETUP = 3'd6
   } state_t;

   function automatic int strobe_cw(input int wait_cycles);
      return $clog2(wait_cycles + 1);
   endfunction
endpackage

// File: rtl/sram_ctrl_if.sv
// rtl/sram_ctrl_if.sv - host-side request/response bundle for the SRAM bus master
interface sram_ctrl_if #(
   parameter int AWIDTH = 8,
   parameter int DWIDTH = 8
);
   logic              req;
   logic              we;
   logic [AWIDTH-1:0] addr;
   logic [DWIDTH-1:0] wdata;
   logic              ready;
   logic              done;
   logic [DWIDTH-1:0] rdata;
   logic              verify_err;

   modport master (output req, we, addr, wdata, input ready, done, rdata, verify_err);
   modport slave  (input req, we, addr, wdata, output ready, done, rdata, verify_err);
endinterface

// File: rtl/sram_wait_timer.sv
// rtl/sram_wait_timer.sv - loadable down-counter timing the SRAM strobe width
module sram_wait_timer
   import sram_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = 6,
   parameter int CW          = strobe_cw(WAIT_CYCLES)
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic load_i,
   output logic last_o
);
   localparam logic [CW-1:0] LOAD_VAL = CW'(WAIT_CYCLES - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   // Loaded one cycle before the strobe so the strobe lasts exactly WAIT_CYCLES.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = LOAD_VAL;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign last_o = (cnt_q == '0);
endmodule

// File: rtl/sram_ctrl.sv
// rtl/sram_ctrl.sv - wait-stated master for the async SRAM bus (_OE/_WE/A/D)
// Optional write-readback check enabled by SRAM_VERIFY_EN.
module sram_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int AWIDTH      = 8,
   parameter int DWIDTH      = 8,
   parameter int WAIT_CYCLES = 6
) (
   input  logic              clk_i,
   input  logic              mr_n_i,
   sram_ctrl_if.slave        host,
   output logic              oe_n_o,
   output logic              we_n_o,
   output logic [AWIDTH-1:0] a_o,
   inout  wire  [DWIDTH-1:0] d_io
);
   state_t            state_q, state_d;
   logic              we_q;
   logic [AWIDTH-1:0] a_q;
   logic [DWIDTH-1:0] wdata_q, rdata_q;
   logic              oe_n_q, we_n_q, d_oe_q, ready_q, done_q;
   logic              timer_load, strobe_last, accept, we_next;

   sram_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
      .clk_i   (clk_i),
      .rst_n_i (mr_n_i),
      .load_i  (timer_load),
      .last_o  (strobe_last)
   );

   assign accept  = (state_q == S_IDLE) && host.req;
   assign we_next = accept ? host.we : we_q;

   always_comb begin
      state_d    = state_q;
      timer_load = 1'b0;
      case (state_q)
         S_IDLE:   if (host.req) state_d = S_SETUP;
         S_SETUP: begin
            timer_load = 1'b1;
            state_d    = we_q ? S_WSTRB : S_RSTRB;
         end
         S_WSTRB:  if (strobe_last) state_d = S_WHOLD;
         S_WHOLD: begin
`ifdef SRAM_VERIFY_EN
            state_d = S_VSETUP;
`else
            state_d = S_IDLE;
`endif
         end
         S_VSETUP: begin
            timer_load = 1'b1;
            state_d    = S_RSTRB;
         end
         S_RSTRB:  if (strobe_last) state_d = S_TURN;
         S_TURN:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // Bus controls are decoded from the next state so every pin leaves a flop.
   always_ff @(posedge clk_i or negedge mr_n_i) begin
      if (!mr_n_i) begin
         state_q <= S_IDLE;
         we_q    <= 1'b0;
         a_q     <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         oe_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
         d_oe_q  <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         oe_n_q  <= (state_d != S_RSTRB);
         we_n_q  <= (state_d != S_WSTRB);
         d_oe_q  <= ((state_d == S_SETUP) && we_next) ||
                    (state_d == S_WSTRB) || (state_d == S_WHOLD);
         ready_q <= (state_d == S_IDLE);
         done_q  <= (state_q != S_IDLE) && (state_d == S_IDLE);
         if (accept) begin
            we_q    <= host.we;
            a_q     <= host.addr;
            wdata_q <= host.wdata;
         end
         if ((state_q == S_RSTRB) && strobe_last && !we_q) begin
            rdata_q <= d_io;
         end
      end
   end

`ifdef SRAM_VERIFY_EN
   logic [DWIDTH-1:0] cap_q;
   logic              verr_q;

   always_ff @(posedge clk_i or negedge mr_n_i) begin
      if (!mr_n_i) begin
         cap_q  <= '0;
         verr_q <= 1'b0;
      end else begin
         if ((state_q == S_RSTRB) && strobe_last && we_q) begin
            cap_q <= d_io;
         end
         if ((state_q == S_TURN) && we_q && (cap_q != wdata_q)) begin
            verr_q <= 1'b1;
         end
      end
   end

   assign host.verify_err = verr_q;
`else
   assign host.verify_err = 1'b0;
`endif

   assign host.ready = ready_q;
   assign host.done  = done_q;
   assign host.rdata = rdata_q;
   assign oe_n_o     = oe_n_q;
   assign we_n_o     = we_n_q;
   assign a_o        = a_q;
   assign d_io       = d_oe_q ? wdata_q : {DWIDTH{1'bz}};
endmodule
